// File: rtl/bcd2bin_seq.sv
// Sequential BCD-to-binary converter (reverse double-dabble); result BIN_WIDTH+1 cycles after start.
// No queuing: start is ignored while busy; done pulses for one cycle in FINISH.
module bcd2bin_seq #(
   parameter int BCD_DIGITS = 3,
   parameter int BIN_WIDTH  = 10
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic [4*BCD_DIGITS-1:0]   bcd_in,
   output logic                      busy,
   output logic                      done,
   output logic [BIN_WIDTH-1:0]      bin_out,
   output logic                      err
);

   localparam int BCD_W = 4 * BCD_DIGITS;
   localparam int CNT_W = $clog2(BIN_WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      FINISH = 2'd2
   } state_t;

   state_t               state, state_nxt;
   logic [BCD_W-1:0]     bcd_reg, bcd_shift;
   logic [BIN_WIDTH-1:0] bin_reg, bin_shift;
   logic [CNT_W-1:0]     cnt;
   logic                 digit_bad;
   logic                 last_iter;

   always_comb begin
      digit_bad = 1'b0;
      for (int i = 0; i < BCD_DIGITS; i++) begin
         if (bcd_in[4*i +: 4] > 4'd9) digit_bad = 1'b1;
      end
   end

   // One reverse double-dabble step: shift the pair right, then pull every digit >=8 back by 3.
   always_comb begin
      bcd_shift = {1'b0, bcd_reg[BCD_W-1:1]};
      bin_shift = {bcd_reg[0], bin_reg[BIN_WIDTH-1:1]};
      for (int i = 0; i < BCD_DIGITS; i++) begin
         if (bcd_shift[4*i +: 4] >= 4'd8) bcd_shift[4*i +: 4] = bcd_shift[4*i +: 4] - 4'd3;
      end
   end

   assign last_iter = (cnt == CNT_W'(BIN_WIDTH - 1));

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nxt = digit_bad ? FINISH : SHIFT;
         end
         SHIFT: begin
            busy = 1'b1;
            if (last_iter) state_nxt = FINISH;
         end
         FINISH: begin
            busy      = 1'b1;
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Results are loaded on the edge that enters FINISH and held until the next one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bcd_reg <= '0;
         bin_reg <= '0;
         cnt     <= '0;
         bin_out <= '0;
         err     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  bcd_reg <= bcd_in;
                  bin_reg <= '0;
                  cnt     <= '0;
                  if (digit_bad) begin
                     bin_out <= '0;
                     err     <= 1'b1;
                  end
               end
            end
            SHIFT: begin
               bcd_reg <= bcd_shift;
               bin_reg <= bin_shift;
               cnt     <= cnt + CNT_W'(1);
               if (last_iter) begin
                  bin_out <= bin_shift;
                  err     <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
